// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending coin paths (acceptance and payout).
//   - Denomination one-hot codes, matching the acceptance switches:
//     bit0=1, bit1=5, bit2=10, bit3=20.
//   - Denomination values in units.
//   - Payout FSM state enum.
//   - MAX_BAL: largest balance either path will handle.
//   - coin_value(): one-hot code to value in units.
// -----------------------------------------------------------------------------
package vending_pkg;

    localparam int unsigned MAX_BAL = 79;

    localparam logic [3:0] COIN_1  = 4'b0001;
    localparam logic [3:0] COIN_5  = 4'b0010;
    localparam logic [3:0] COIN_10 = 4'b0100;
    localparam logic [3:0] COIN_20 = 4'b1000;

    localparam logic [6:0] VAL_1  = 7'd1;
    localparam logic [6:0] VAL_5  = 7'd5;
    localparam logic [6:0] VAL_10 = 7'd10;
    localparam logic [6:0] VAL_20 = 7'd20;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_ISSUE,
        ST_DONE,
        ST_FAULT
    } disp_state_e;

    function automatic logic [6:0] coin_value(input logic [3:0] sel);
        logic [6:0] v;
        case (sel)
            COIN_1:  v = VAL_1;
            COIN_5:  v = VAL_5;
            COIN_10: v = VAL_10;
            COIN_20: v = VAL_20;
            default: v = 7'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/change_dispenser_denom_select.sv
// -----------------------------------------------------------------------------
// denom_select
// Combinational greedy picker: chooses the largest denomination that does not
// exceed the amount still owed (and, with CHANGE_INVENTORY_EN, whose tube is
// not empty).
// Optional feature macro: CHANGE_INVENTORY_EN (adds empty_i).
// Ports:
//   remaining_i  in  7  amount still owed
//   empty_i      in  4  tube-empty mask, one bit per denomination (optional)
//   sel_o        out 4  one-hot chosen denomination, 0 when none
//   value_o      out 7  value of sel_o in units
//   none_o       out 1  no usable denomination fits remaining_i
// -----------------------------------------------------------------------------
module denom_select
    import vending_pkg::*;
(
    input  logic [6:0] remaining_i,
`ifdef CHANGE_INVENTORY_EN
    input  logic [3:0] empty_i,
`endif
    output logic [3:0] sel_o,
    output logic [6:0] value_o,
    output logic       none_o
);

    logic [3:0] avail;

    always_comb begin
        avail = 4'b1111;
`ifdef CHANGE_INVENTORY_EN
        avail = ~empty_i;
`endif
        sel_o   = 4'b0000;
        value_o = 7'd0;
        none_o  = 1'b1;
        if (avail[3] && remaining_i >= VAL_20) begin
            sel_o   = COIN_20;
            value_o = VAL_20;
            none_o  = 1'b0;
        end else if (avail[2] && remaining_i >= VAL_10) begin
            sel_o   = COIN_10;
            value_o = VAL_10;
            none_o  = 1'b0;
        end else if (avail[1] && remaining_i >= VAL_5) begin
            sel_o   = COIN_5;
            value_o = VAL_5;
            none_o  = 1'b0;
        end else if (avail[0] && remaining_i >= VAL_1) begin
            sel_o   = COIN_1;
            value_o = VAL_1;
            none_o  = 1'b0;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
// Pays a balance back as coins, largest denomination first, one coin at a
// time over a coin_valid / hopper_ack handshake. A hopper that never acks
// within ACK_TIMEOUT ISSUE cycles latches a sticky fault until rst.
// Optional feature macro: CHANGE_INVENTORY_EN (per-denomination tube
// counters, inv_reload input, fault when no usable coin remains).
// Ports:
//   clk         in  1  system clock
//   rst         in  1  synchronous active-high reset
//   refund_req  in  1  start payout of balance (IDLE only)
//   balance     in  7  amount to pay, clamped to MAX_BAL
//   hopper_ack  in  1  hopper took the presented coin (ISSUE only)
//   inv_reload  in  1  refill all tubes to 15 in IDLE (optional)
//   coin_valid  out 1  coin presented to hopper
//   coin_sel    out 4  one-hot denomination presented
//   busy        out 1  payout in progress or faulted
//   done        out 1  one-cycle completion pulse
//   fault       out 1  sticky hopper-timeout / out-of-coins flag
//   remaining   out 7  amount still owed
//   coin_count  out 4  coins issued this payout, saturating at 15
//
// state  | meaning
// IDLE   | waiting for refund_req
// SELECT | pick next coin, or finish when nothing is owed
// ISSUE  | coin presented, waiting for hopper_ack under timeout
// DONE   | single-cycle done pulse
// FAULT  | hopper or inventory failure, held until rst
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int unsigned MAX_BAL     = vending_pkg::MAX_BAL,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refund_req,
    input  logic [6:0] balance,
    input  logic       hopper_ack,
`ifdef CHANGE_INVENTORY_EN
    input  logic       inv_reload,
`endif
    output logic       coin_valid,
    output logic [3:0] coin_sel,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [6:0] remaining,
    output logic [3:0] coin_count
);
    import vending_pkg::*;

    localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMR_LAST  = TW'(ACK_TIMEOUT - 1);
    localparam logic [6:0]    BAL_CLAMP = 7'(MAX_BAL);

    disp_state_e   state_q, state_d;
    logic          coin_valid_q, coin_valid_d;
    logic [3:0]    coin_sel_q, coin_sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [6:0]    remaining_q, remaining_d;
    logic [3:0]    coin_count_q, coin_count_d;
    logic [TW-1:0] timer_q, timer_d;

    logic [3:0]    pick_sel;
    logic [6:0]    pick_value;
    logic          pick_none;

`ifdef CHANGE_INVENTORY_EN
    logic [3:0][3:0] tube_q, tube_d;
    logic [3:0]      tube_empty;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tube_empty[i] = (tube_q[i] == 4'd0);
        end
    end
`endif

    denom_select u_denom_select (
        .remaining_i (remaining_q),
`ifdef CHANGE_INVENTORY_EN
        .empty_i     (tube_empty),
`endif
        .sel_o       (pick_sel),
        .value_o     (pick_value),
        .none_o      (pick_none)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            coin_valid_q <= 1'b0;
            coin_sel_q   <= 4'b0000;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            remaining_q  <= 7'd0;
            coin_count_q <= 4'd0;
            timer_q      <= '0;
`ifdef CHANGE_INVENTORY_EN
            tube_q       <= {4{4'd15}};
`endif
        end else begin
            state_q      <= state_d;
            coin_valid_q <= coin_valid_d;
            coin_sel_q   <= coin_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fault_q      <= fault_d;
            remaining_q  <= remaining_d;
            coin_count_q <= coin_count_d;
            timer_q      <= timer_d;
`ifdef CHANGE_INVENTORY_EN
            tube_q       <= tube_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        coin_valid_d = coin_valid_q;
        coin_sel_d   = coin_sel_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        fault_d      = fault_q;
        remaining_d  = remaining_q;
        coin_count_d = coin_count_q;
        timer_d      = timer_q;
`ifdef CHANGE_INVENTORY_EN
        tube_d       = tube_q;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef CHANGE_INVENTORY_EN
                if (inv_reload) begin
                    tube_d = {4{4'd15}};
                end
`endif
                if (refund_req) begin
                    if (balance != 7'd0) begin
                        remaining_d  = (balance > BAL_CLAMP) ? BAL_CLAMP : balance;
                        coin_count_d = 4'd0;
                        busy_d       = 1'b1;
                        state_d      = ST_SELECT;
                    end else begin
                        // Nothing owed: straight to the completion pulse.
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_SELECT: begin
                if (remaining_q == 7'd0) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else if (pick_none) begin
                    // Only reachable with empty tubes; debt cannot be paid.
                    coin_valid_d = 1'b0;
                    fault_d      = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_FAULT;
                end else begin
                    coin_sel_d   = pick_sel;
                    coin_valid_d = 1'b1;
                    timer_d      = '0;
                    state_d      = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                // Ack is checked before the timer so a last-cycle ack wins.
                if (hopper_ack) begin
                    coin_valid_d = 1'b0;
                    remaining_d  = remaining_q - coin_value(coin_sel_q);
                    if (coin_count_q != 4'd15) begin
                        coin_count_d = coin_count_q + 4'd1;
                    end
`ifdef CHANGE_INVENTORY_EN
                    for (int i = 0; i < 4; i++) begin
                        if (coin_sel_q[i] && tube_q[i] != 4'd0) begin
                            tube_d[i] = tube_q[i] - 4'd1;
                        end
                    end
`endif
                    state_d = ST_SELECT;
                end else if (timer_q == TMR_LAST) begin
                    coin_valid_d = 1'b0;
                    fault_d      = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ST_FAULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            ST_FAULT: begin
                coin_valid_d = 1'b0;
                fault_d      = 1'b1;
                busy_d       = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign coin_valid = coin_valid_q;
    assign coin_sel   = coin_sel_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign remaining  = remaining_q;
    assign coin_count = coin_count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
// Directed and randomized payouts checked against a greedy-change model.
// Build with CHANGE_INVENTORY_EN defined to also exercise the tube counters.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       refund_req;
    logic [6:0] balance;
    logic       hopper_ack;
`ifdef CHANGE_INVENTORY_EN
    logic       inv_reload;
`endif
    logic       coin_valid;
    logic [3:0] coin_sel;
    logic       busy;
    logic       done;
    logic       fault;
    logic [6:0] remaining;
    logic [3:0] coin_count;

    int errors = 0;
    int checks = 0;

    // Model state: denominations largest first, tube stock, expected coins.
    int val_tab[4] = '{20, 10, 5, 1};
    int tube_m[4];
    int exp_val[$];
    int exp_left;

    always #5 clk = ~clk;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .refund_req (refund_req),
        .balance    (balance),
        .hopper_ack (hopper_ack),
`ifdef CHANGE_INVENTORY_EN
        .inv_reload (inv_reload),
`endif
        .coin_valid (coin_valid),
        .coin_sel   (coin_sel),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .remaining  (remaining),
        .coin_count (coin_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sel_of(input int v);
        case (v)
            1:       return 1;
            5:       return 2;
            10:      return 4;
            20:      return 8;
            default: return 0;
        endcase
    endfunction

    task automatic fill_tubes();
        for (int k = 0; k < 4; k++) begin
`ifdef CHANGE_INVENTORY_EN
            tube_m[k] = 15;
`else
            tube_m[k] = 1000000;
`endif
        end
    endtask

    // Greedy change with stock limits; exp_left > 0 means the payout must fault.
    task automatic model(input int bal);
        int amt;
        amt = (bal > 79) ? 79 : bal;
        exp_val.delete();
        for (int k = 0; k < 4; k++) begin
            while (amt >= val_tab[k] && tube_m[k] > 0) begin
                exp_val.push_back(val_tab[k]);
                amt -= val_tab[k];
                tube_m[k]--;
            end
        end
        exp_left = amt;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".coin_valid"}, coin_valid, 0);
        check({tag, ".coin_sel"},   coin_sel,   0);
        check({tag, ".busy"},       busy,       0);
        check({tag, ".done"},       done,       0);
        check({tag, ".fault"},      fault,      0);
        check({tag, ".remaining"},  remaining,  0);
        check({tag, ".coin_count"}, coin_count, 0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fill_tubes();
        check_reset(tag);
    endtask

    task automatic reload();
`ifdef CHANGE_INVENTORY_EN
        inv_reload = 1'b1;
        tick();
        inv_reload = 1'b0;
`endif
        fill_tubes();
    endtask

    task automatic run_payout(input int bal, input int dmin, input int dmax);
        int amt;
        int paid;
        int delay;
        int n;
        amt = (bal > 79) ? 79 : bal;
        model(bal);
        n = exp_val.size();
        refund_req = 1'b1;
        balance    = 7'(bal);
        tick();
        refund_req = 1'b0;
        if (amt == 0) begin
            check("zero.done",       done,       1);
            check("zero.busy",       busy,       0);
            check("zero.coin_valid", coin_valid, 0);
            tick();
            check("zero.done_end",   done,       0);
            check("zero.cv_end",     coin_valid, 0);
            return;
        end
        check("cap.busy",       busy,       1);
        check("cap.remaining",  remaining,  amt);
        check("cap.coin_count", coin_count, 0);
        check("cap.coin_valid", coin_valid, 0);
        paid = 0;
        for (int k = 0; k < n; k++) begin
            tick();
            check("coin.valid", coin_valid, 1);
            check("coin.sel",   coin_sel,   sel_of(exp_val[k]));
            delay = int'($urandom_range(dmax, dmin));
            for (int d = 0; d < delay; d++) begin
                hopper_ack = 1'b0;
                refund_req = 1'($urandom_range(1, 0));
                tick();
                refund_req = 1'b0;
                check("hold.valid", coin_valid, 1);
                check("hold.sel",   coin_sel,   sel_of(exp_val[k]));
            end
            hopper_ack = 1'b1;
            tick();
            hopper_ack = 1'b0;
            paid += exp_val[k];
            check("ack.valid",      coin_valid, 0);
            check("ack.remaining",  remaining,  amt - paid);
            check("ack.coin_count", coin_count, (k + 1 > 15) ? 15 : k + 1);
            check("ack.busy",       busy,       1);
        end
        tick();
        if (exp_left == 0) begin
            check("end.done",       done,       1);
            check("end.busy",       busy,       0);
            check("end.remaining",  remaining,  0);
            check("end.coin_count", coin_count, (n > 15) ? 15 : n);
            tick();
            check("end.done_pulse", done,       0);
            check("end.busy_idle",  busy,       0);
        end else begin
            check("nocoin.fault", fault,      1);
            check("nocoin.busy",  busy,       1);
            check("nocoin.valid", coin_valid, 0);
            check("nocoin.done",  done,       0);
            do_reset("nocoin.rst");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        refund_req = 1'b0;
        balance    = 7'd0;
        hopper_ack = 1'b0;
`ifdef CHANGE_INVENTORY_EN
        inv_reload = 1'b0;
`endif
        fill_tubes();
        tick();
        tick();
        rst = 1'b0;
        check_reset("reset");

        // Ack while idle must not disturb anything.
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        check_reset("idle_ack");

        run_payout(38, 0, 0);
        run_payout(0, 0, 0);
        run_payout(100, 0, 0);
        run_payout(6, 10, 10);
        reload();
        run_payout(79, 0, 2);

        for (int r = 0; r < 12; r++) begin
            reload();
            run_payout(int'($urandom_range(127, 0)), 0, 4);
        end

        // Hopper never acks: fault after exactly ACK_TIMEOUT ISSUE cycles.
        refund_req = 1'b1;
        balance    = 7'd6;
        tick();
        refund_req = 1'b0;
        tick();
        check("to.valid", coin_valid, 1);
        check("to.sel",   coin_sel,   2);
        repeat (254) tick();
        check("to.last_valid", coin_valid, 1);
        check("to.last_fault", fault,      0);
        tick();
        check("to.fault", fault,      1);
        check("to.valid_off", coin_valid, 0);
        check("to.busy",  busy,       1);
        check("to.done",  done,       0);
        refund_req = 1'b1;
        balance    = 7'd20;
        repeat (5) tick();
        refund_req = 1'b0;
        check("to.sticky_fault", fault,      1);
        check("to.sticky_valid", coin_valid, 0);
        check("to.sticky_busy",  busy,       1);
        do_reset("to.rst");

        // Ack on the final allowed cycle beats the timeout.
        model(5);
        refund_req = 1'b1;
        balance    = 7'd5;
        tick();
        refund_req = 1'b0;
        tick();
        check("late.sel", coin_sel, 2);
        repeat (254) tick();
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        check("late.fault",      fault,      0);
        check("late.valid",      coin_valid, 0);
        check("late.remaining",  remaining,  0);
        check("late.coin_count", coin_count, 1);
        tick();
        check("late.done", done, 1);
        tick();

        // Reset in the middle of a payout drops the unpaid balance.
        refund_req = 1'b1;
        balance    = 7'd38;
        tick();
        refund_req = 1'b0;
        tick();
        hopper_ack = 1'b1;
        tick();
        hopper_ack = 1'b0;
        tick();
        check("mid.valid", coin_valid, 1);
        check("mid.sel",   coin_sel,   4);
        do_reset("mid.rst");

`ifdef CHANGE_INVENTORY_EN
        repeat (15) run_payout(20, 0, 0);
        run_payout(40, 0, 1);
        repeat (11) run_payout(10, 0, 0);
        repeat (15) run_payout(5, 0, 0);
        repeat (15) run_payout(1, 0, 0);
        run_payout(3, 0, 0);
        reload();
        run_payout(38, 0, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
